// File: rtl/hop_input_gen_if.sv
// hop_input_gen_if: bundles the link-controller inputs and kernel-facing outputs of hop_input_gen.
// master drives clk_bt/bd_addr/mode/train_b/n_inc/mod_n and observes the kernel inputs; slave is the generator.
interface hop_input_gen_if;
  logic [27:0] clk_bt;
  logic [27:0] bd_addr;
  logic [2:0]  mode;
  logic        train_b;
  logic        n_inc;
  logic [6:0]  mod_n;
  logic [4:0]  X;
  logic [4:0]  C;
  logic [4:0]  A;
  logic [3:0]  B;
  logic [8:0]  D;
  logic [6:0]  E;
  logic [6:0]  F;
  logic [6:0]  Fprime;
  logic        Y1;
  logic [5:0]  Y2;
  logic        kern_valid;
  logic        busy;
  modport master (output clk_bt, bd_addr, mode, train_b, n_inc, mod_n,
                  input X, C, A, B, D, E, F, Fprime, Y1, Y2, kern_valid, busy);
  modport slave  (input clk_bt, bd_addr, mode, train_b, n_inc, mod_n,
                  output X, C, A, B, D, E, F, Fprime, Y1, Y2, kern_valid, busy);
endinterface

// File: rtl/hop_input_gen.sv
// hop_input_gen: registered hop-kernel input generator (X,A..F,F',Y1,Y2) with a 25-cycle restoring mod-79 / mod-N divider.
// Ports: clk, rst (async active-high), h (hop_input_gen_if.slave: clk_bt, bd_addr, mode, train_b, n_inc, mod_n in;
// X, A, B, C, D, E, F, Fprime, Y1, Y2, kern_valid, busy out). Define HOP_INQ_EN to make mode 1 an inquiry train using GIAC_LAP.
module hop_input_gen #(
  parameter logic [4:0] KOFF_A = 5'd24,
  parameter logic [4:0] KOFF_B = 5'd8
`ifdef HOP_INQ_EN
  , parameter logic [23:0] GIAC_LAP = 24'h9E8B33
`endif
) (
  input logic clk,
  input logic rst,
  hop_input_gen_if.slave h
);
  typedef enum logic [2:0] {S_IDLE, S_INQ, S_PAGE, S_PRSP, S_CONN} state_t;
  state_t state, nstate;
  logic [16:0] frz, fz;
  logic [4:0]  n, nn, cnt, koff, nx;
  logic [20:0] ck;
  logic [6:0]  mn, r79, rn, s79, sn;
  logic [7:0]  t79, tn;
  logic [24:0] dv;
  logic        done, done_n, busy_n, trig, fin, bitv, conn, prsp_entry, kv_n, inq;
  logic [27:0] addr;
`ifdef HOP_INQ_EN
  assign inq  = h.mode == 3'd1;
  assign addr = inq ? {4'h0, GIAC_LAP} : h.bd_addr;
`else
  assign inq  = 1'b0;
  assign addr = h.bd_addr;
`endif
  // page-train X before the page-response offset N is added
  function automatic logic [4:0] xpage(input logic [16:0] c, input logic [4:0] k);
    logic [3:0] d;
    d = {c[4:2], c[0]} - c[15:12];
    return c[16:12] + k + {1'b0, d};
  endfunction
  always_comb begin
    nstate = h.mode == 3'd2 ? S_PAGE : h.mode == 3'd3 ? S_PRSP : h.mode == 3'd4 ? S_CONN : inq ? S_INQ : S_IDLE;
    conn = nstate == S_CONN;
    koff = h.train_b ? KOFF_B : KOFF_A;
    prsp_entry = nstate == S_PRSP && state != S_PRSP;
    fz = prsp_entry ? h.clk_bt[16:0] : frz;
    nn = prsp_entry ? 5'd0 : n + {4'b0, h.n_inc};
    nx = conn ? h.clk_bt[6:2] : nstate == S_PRSP ? xpage(fz, koff) + nn : xpage(h.clk_bt[16:0], koff);
    dv = {ck, 4'b0};
    bitv = dv[cnt];
    t79 = {r79, bitv};
    tn = {rn, bitv};
    s79 = 7'(t79 >= 8'd79 ? t79 - 8'd79 : t79);
    sn = 7'(tn >= {1'b0, mn} ? tn - {1'b0, mn} : tn);
    // any trigger restarts from bit 24 so the latest dividend/divisor wins
    trig = conn && (state != S_CONN || h.clk_bt[27:7] != ck || h.mod_n != mn);
    fin = h.busy && conn && !trig && cnt == 5'd0;
    busy_n = trig || (h.busy && conn && cnt != 5'd0);
    done_n = conn && state != S_CONN ? 1'b0 : done || fin;
    kv_n = conn ? !busy_n && done_n : nstate != S_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= nstate;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frz <= '0;
      n <= '0;
      ck <= '0;
      mn <= '0;
      r79 <= '0;
      rn <= '0;
      cnt <= '0;
      done <= 1'b0;
      h.X <= '0;
      h.A <= '0;
      h.B <= '0;
      h.C <= '0;
      h.D <= '0;
      h.E <= '0;
      h.F <= '0;
      h.Fprime <= '0;
      h.Y1 <= 1'b0;
      h.Y2 <= '0;
      h.busy <= 1'b0;
      h.kern_valid <= 1'b0;
    end else begin
      h.busy <= busy_n;
      h.kern_valid <= kv_n;
      done <= done_n;
      if (prsp_entry) frz <= h.clk_bt[16:0];
      if (nstate == S_PRSP) n <= nn;
      if (trig) begin
        ck <= h.clk_bt[27:7];
        mn <= h.mod_n;
        r79 <= '0;
        rn <= '0;
        cnt <= 5'd24;
      end else if (busy_n) begin
        r79 <= s79;
        rn <= sn;
        cnt <= cnt - 5'd1;
      end
      if (nstate != S_IDLE) begin
        h.X <= nx;
        h.A <= addr[27:23] ^ (conn ? h.clk_bt[25:21] : 5'd0);
        h.B <= addr[22:19];
        h.C <= {addr[8], addr[6], addr[4], addr[2], addr[0]} ^ (conn ? h.clk_bt[20:16] : 5'd0);
        h.D <= addr[18:10] ^ (conn ? h.clk_bt[15:7] : 9'd0);
        h.E <= {addr[13], addr[11], addr[9], addr[7], addr[5], addr[3], addr[1]};
        h.Y1 <= h.clk_bt[1];
        h.Y2 <= {h.clk_bt[1], 5'b0};
        h.F <= conn ? (fin ? s79 : h.F) : 7'd0;
        h.Fprime <= conn ? (fin ? sn : h.Fprime) : 7'd0;
      end
    end
  end
endmodule
